// File: rtl/regmgr_pkg.sv
// rtl/regmgr_pkg.sv - shared types and constants for the register-renew dispatcher
// Contents:
//   lane_state_t  per-processor lane tracking state
//   top_state_t   dispatcher state (normal issue, draining, waiting for sync)
//   LANE_MAIN/LANE_SUB  encoding of issue_proc
package regmgr_pkg;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_ARM  = 2'd1,
    LANE_BUSY = 2'd2
  } lane_state_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    SYNC_WAIT = 2'd2
  } top_state_t;

  localparam logic LANE_MAIN = 1'b0;
  localparam logic LANE_SUB  = 1'b1;

endpackage

// File: rtl/register_renew_dispatcher_if.sv
// rtl/register_renew_dispatcher_if.sv - work-item issue handshake between manager and dispatcher
// Signals:
//   issue_valid  manager offers a work item
//   issue_rd     destination register of the item
//   issue_ready  dispatcher accepts the item this cycle
//   issue_proc   lane of the last booted item (0 = main, 1 = sub)
// Modports: master = manager side, slave = dispatcher side.
interface register_renew_dispatcher_if #(
  parameter int REG_CTN_WIDTH = 5
);
  logic                     issue_valid;
  logic [REG_CTN_WIDTH-1:0] issue_rd;
  logic                     issue_ready;
  logic                     issue_proc;

  modport master (output issue_valid, issue_rd, input issue_ready, issue_proc);
  modport slave  (input issue_valid, issue_rd, output issue_ready, issue_proc);
endinterface

// File: rtl/renew_lane_tracker.sv
// rtl/renew_lane_tracker.sv - follows one processor lane from boot until its register leaves the table
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   boot        lane is booted this cycle (only honoured from LANE_IDLE)
//   rd          register captured on boot
//   reg_table   processing register table
//   state       lane state
//   lane_rd     register currently owned by the lane
module renew_lane_tracker
  import regmgr_pkg::*;
#(
  parameter int REGISTER_AMOUNT = 32,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       boot,
  input  logic [REG_CTN_WIDTH-1:0]   rd,
  input  logic [0:REGISTER_AMOUNT-1] reg_table,
  output lane_state_t                state,
  output logic [REG_CTN_WIDTH-1:0]   lane_rd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LANE_IDLE;
      lane_rd <= '0;
    end else begin
      case (state)
        LANE_IDLE: begin
          if (boot) begin
            state   <= LANE_ARM;
            lane_rd <= rd;
          end
        end
        // The table bit is not set yet in the cycle right after the boot
        // pulse, so skip one cycle before watching it.
        LANE_ARM:  state <= LANE_BUSY;
        LANE_BUSY: if (!reg_table[lane_rd]) state <= LANE_IDLE;
        default:   state <= LANE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/register_renew_dispatcher.sv
// rtl/register_renew_dispatcher.sv - picks a free processor lane per work item and runs sync handshake
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   issue (slave)                    work-item handshake, issue_proc reports last booted lane
//   processor_idle_1/2               processor idle flags
//   processing_register_table        registers currently being renewed
//   synchronized_processors          both processors report synchronized
//   boot_renew_register_1/2          one-cycle boot pulses
//   register_num                     register of the current boot pulse
//   sync_request                     request a synchronization (honoured only in RUN)
//   sync_done / sync_error           one-cycle result pulses
//   busy                             a lane is tracking or a sync is in progress
module register_renew_dispatcher
  import regmgr_pkg::*;
#(
  parameter int REGISTER_AMOUNT = 32,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
  parameter int SYNC_TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  register_renew_dispatcher_if.slave issue,
  input  logic                       processor_idle_1,
  input  logic                       processor_idle_2,
  input  logic [0:REGISTER_AMOUNT-1] processing_register_table,
  input  logic                       synchronized_processors,
  output logic                       boot_renew_register_1,
  output logic                       boot_renew_register_2,
  output logic [REG_CTN_WIDTH-1:0]   register_num,
  input  logic                       sync_request,
  output logic                       sync_done,
  output logic                       sync_error,
  output logic                       busy
);

  localparam int CNT_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT - 1);

  top_state_t               top_state;
  logic [CNT_W-1:0]         sync_count;
  lane_state_t              lane_state [2];
  logic [REG_CTN_WIDTH-1:0] lane_rd    [2];
  logic [1:0]               proc_idle;
  logic [1:0]               lane_free;
  logic [1:0]               lane_hit;
  logic [1:0]               lane_boot;
  logic                     hazard;
  logic                     rd_zero;
  logic                     accept;

  assign proc_idle = {processor_idle_2, processor_idle_1};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    renew_lane_tracker #(
      .REGISTER_AMOUNT(REGISTER_AMOUNT),
      .REG_CTN_WIDTH  (REG_CTN_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .boot     (lane_boot[g]),
      .rd       (issue.issue_rd),
      .reg_table(processing_register_table),
      .state    (lane_state[g]),
      .lane_rd  (lane_rd[g])
    );
  end

  always_comb begin
    rd_zero = (issue.issue_rd == '0);
    for (int i = 0; i < 2; i++) begin
      lane_free[i] = (lane_state[i] == LANE_IDLE) && proc_idle[i];
      lane_hit[i]  = (lane_state[i] != LANE_IDLE) && (lane_rd[i] == issue.issue_rd);
    end
    hazard = processing_register_table[issue.issue_rd] || (|lane_hit);
    // rst_n keeps ready low while reset is held; the top FSM already sits
    // in RUN during reset, so it would otherwise advertise acceptance.
    issue.issue_ready = rst_n && (top_state == RUN) && !hazard && ((|lane_free) || rd_zero);
    accept = issue.issue_valid && issue.issue_ready;
    // Register 0 is accepted and dropped. Lane 1 has priority; when it is
    // not free, acceptance of a non-zero register implies lane 2 is free.
    lane_boot[0] = accept && !rd_zero && lane_free[0];
    lane_boot[1] = accept && !rd_zero && !lane_free[0];
    busy = (top_state != RUN) || (lane_state[0] != LANE_IDLE) || (lane_state[1] != LANE_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_state             <= RUN;
      sync_count            <= '0;
      sync_done             <= 1'b0;
      sync_error            <= 1'b0;
      boot_renew_register_1 <= 1'b0;
      boot_renew_register_2 <= 1'b0;
      register_num          <= '0;
      issue.issue_proc      <= LANE_MAIN;
    end else begin
      boot_renew_register_1 <= lane_boot[0];
      boot_renew_register_2 <= lane_boot[1];
      sync_done             <= 1'b0;
      sync_error            <= 1'b0;
      if (|lane_boot) begin
        register_num     <= issue.issue_rd;
        issue.issue_proc <= lane_boot[1] ? LANE_SUB : LANE_MAIN;
      end
      case (top_state)
        RUN: if (sync_request) top_state <= DRAIN;
        DRAIN: begin
          if ((lane_state[0] == LANE_IDLE) && (lane_state[1] == LANE_IDLE)) begin
            top_state  <= SYNC_WAIT;
            sync_count <= '0;
          end
        end
        SYNC_WAIT: begin
          if (synchronized_processors) begin
            sync_done <= 1'b1;
            top_state <= RUN;
          end else if (sync_count == CNT_LAST) begin
            sync_error <= 1'b1;
            top_state  <= RUN;
          end else begin
            sync_count <= sync_count + CNT_W'(1);
          end
        end
        default: top_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_register_renew_dispatcher.sv
// tb/tb_register_renew_dispatcher.sv - directed and randomized checks of register_renew_dispatcher against a lane-occupancy model
module tb_register_renew_dispatcher;

  localparam int RA = 32;
  localparam int W  = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          idle_1, idle_2;
  logic [0:RA-1] tbl;
  logic          synced, sreq;
  logic          boot_1, boot_2;
  logic [W-1:0]  num;
  logic          done, err, busy;

  always #5 clk = ~clk;

  register_renew_dispatcher_if #(.REG_CTN_WIDTH(W)) issue_if ();

  register_renew_dispatcher #(
    .REGISTER_AMOUNT(RA),
    .REG_CTN_WIDTH  (W),
    .SYNC_TIMEOUT   (TO)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .issue                    (issue_if),
    .processor_idle_1         (idle_1),
    .processor_idle_2         (idle_2),
    .processing_register_table(tbl),
    .synchronized_processors  (synced),
    .boot_renew_register_1    (boot_1),
    .boot_renew_register_2    (boot_2),
    .register_num             (num),
    .sync_request             (sreq),
    .sync_done                (done),
    .sync_error               (err),
    .busy                     (busy)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Model: each lane owns a register (-1 = none) and knows how long it has owned it.
  int           m_mode;        // 0 normal, 1 draining, 2 waiting for sync
  int           m_cnt;
  int           lane_reg [2];
  int           lane_age [2];
  logic         e_boot_1, e_boot_2, e_done, e_err, e_proc;
  logic [W-1:0] e_num;

  // Environment: the register-management block sets a booted register's
  // table bit two cycles after acceptance and keeps it for hold[] cycles.
  int hold      [RA];
  int set_delay [RA];
  int hold_len;
  bit noise;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    for (int l = 0; l < 2; l++) begin
      lane_reg[l] = -1;
      lane_age[l] = 0;
    end
    e_boot_1 = 1'b0; e_boot_2 = 1'b0; e_done = 1'b0; e_err = 1'b0; e_proc = 1'b0;
    e_num = '0;
    for (int r = 0; r < RA; r++) begin
      hold[r]      = 0;
      set_delay[r] = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic v, input logic [W-1:0] rd, input logic i1, input logic i2,
                       input logic sr, input logic sy);
    logic e_ready;
    bit   occ0, occ1, fr0, fr1, haz;
    int   rdi;
    rdi = int'(rd);
    expect_eq("boot_1", boot_1, e_boot_1);
    expect_eq("boot_2", boot_2, e_boot_2);
    expect_eq("register_num", num, e_num);
    expect_eq("issue_proc", issue_if.issue_proc, e_proc);
    expect_eq("sync_done", done, e_done);
    expect_eq("sync_error", err, e_err);
    expect_eq("busy", busy, (m_mode != 0) || (lane_reg[0] >= 0) || (lane_reg[1] >= 0));

    for (int r = 0; r < RA; r++) begin
      if (set_delay[r] > 0) begin
        set_delay[r]--;
        if (set_delay[r] == 0) hold[r] = (hold_len > 0) ? hold_len : $urandom_range(1, 12);
      end
    end
    if (noise && ($urandom_range(0, 15) == 0)) begin
      int r;
      r = $urandom_range(0, RA - 1);
      if (hold[r] == 0) hold[r] = $urandom_range(1, 6);
    end
    for (int r = 0; r < RA; r++) tbl[r] = (hold[r] > 0);
    issue_if.issue_valid = v;
    issue_if.issue_rd    = rd;
    idle_1 = i1;
    idle_2 = i2;
    sreq   = sr;
    synced = sy;
    #1;

    occ0 = (lane_reg[0] >= 0);
    occ1 = (lane_reg[1] >= 0);
    fr0  = !occ0 && i1;
    fr1  = !occ1 && i2;
    haz  = tbl[rd] || (occ0 && lane_reg[0] == rdi) || (occ1 && lane_reg[1] == rdi);
    e_ready = (m_mode == 0) && !haz && (fr0 || fr1 || rdi == 0);
    expect_eq("issue_ready", issue_if.issue_ready, e_ready);

    e_boot_1 = 1'b0; e_boot_2 = 1'b0; e_done = 1'b0; e_err = 1'b0;
    case (m_mode)
      0: if (sr) m_mode = 1;
      1: if (!occ0 && !occ1) begin m_mode = 2; m_cnt = 0; end
      default: begin
        if (sy) begin e_done = 1'b1; m_mode = 0; end
        else if (m_cnt == TO - 1) begin e_err = 1'b1; m_mode = 0; end
        else m_cnt++;
      end
    endcase
    // A lane lets go once it has owned its register for at least one full
    // cycle and the table no longer shows that register.
    for (int l = 0; l < 2; l++) begin
      if (lane_reg[l] >= 0) begin
        if (lane_age[l] >= 1 && !tbl[lane_reg[l]]) lane_reg[l] = -1;
        else lane_age[l]++;
      end
    end
    if (v && e_ready && rdi != 0) begin
      int l;
      l = fr0 ? 0 : 1;
      lane_reg[l] = rdi;
      lane_age[l] = 0;
      e_num  = rd;
      e_proc = (l == 1);
      if (l == 0) e_boot_1 = 1'b1; else e_boot_2 = 1'b1;
      set_delay[rdi] = 2;
    end
    for (int r = 0; r < RA; r++) if (hold[r] > 0) hold[r]--;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    expect_eq({tag, "_ready"}, issue_if.issue_ready, 1'b0);
    expect_eq({tag, "_proc"}, issue_if.issue_proc, 1'b0);
    expect_eq({tag, "_boot_1"}, boot_1, 1'b0);
    expect_eq({tag, "_boot_2"}, boot_2, 1'b0);
    expect_eq({tag, "_num"}, num, '0);
    expect_eq({tag, "_done"}, done, 1'b0);
    expect_eq({tag, "_error"}, err, 1'b0);
    expect_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    issue_if.issue_valid = 1'b0;
    issue_if.issue_rd    = '0;
    idle_1 = 1'b1; idle_2 = 1'b1;
    tbl = '0; synced = 1'b0; sreq = 1'b0;
    model_reset();
    hold_len = 10;
    noise    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // rd=5 then the same rd again: stalls on the lane and then the table
    cycle(1'b1, W'(5), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (14) cycle(1'b1, W'(5), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (14) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    // rd=3, rd=7 back to back, then rd=9 waits for a lane
    cycle(1'b1, W'(3), 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, W'(7), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (16) cycle(1'b1, W'(9), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (16) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    // register 0 is accepted and dropped
    cycle(1'b1, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    // sync request while lane 2 is busy; items offered during drain must stall
    cycle(1'b1, W'(3), 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, W'(4), 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40 && m_mode != 2; k++) cycle(1'b1, W'(6), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b1);
    // timeout with synchronized held low
    cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (22) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    // reset asserted in the middle of SYNC_WAIT
    cycle(1'b1, W'(11), 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40 && m_mode != 2; k++) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    tbl = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    hold_len = 0;
    noise    = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] rd;
      if ($urandom_range(0, 7) == 0) rd = '0;
      else if ($urandom_range(0, 3) == 0) rd = W'($urandom_range(1, RA - 1));
      else rd = W'($urandom_range(1, 8));
      cycle(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
